// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Two-requester arbiter for the shared instruction/data memory
//             port. Each granted access is latched and held on the memory bus
//             for WAIT_STATES extra cycles, then acknowledged with registered
//             read data. Ties are resolved round-robin; defining
//             MEM_ARB_FIXED_PRIO_EN makes requester 0 always win ties.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 1      // legal range 0..15 (4-bit counter)
) (
    input  logic                  clk,
    input  logic                  reset,      // asynchronous, active low
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_STATES);

    state_t                  r_state;
    state_t                  w_nextState;
    logic                    w_grant;      // IDLE with at least one request
    logic                    w_capture;    // final ACCESS cycle
    logic                    w_pick;       // requester chosen this cycle
    logic [3:0]              r_cnt;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_grantId;
    logic [DATA_WIDTH-1:0]   r_m0Rdata;
    logic [DATA_WIDTH-1:0]   r_m1Rdata;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Tie-break: requester 0 always wins, so no grant history is kept.
    always_comb begin
        w_pick = 1'b0;
        if (!m0_req && m1_req) begin
            w_pick = 1'b1;
        end
    end
`else
    logic r_lastGnt;

    // Tie-break: the requester that did not win last time gets the port.
    always_comb begin
        w_pick = 1'b0;
        if (m0_req && m1_req) begin
            w_pick = ~r_lastGnt;
        end else if (m1_req) begin
            w_pick = 1'b1;
        end
    end

    // Remember the last winner; reset value hands the first tie to requester 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lastGnt <= 1'b1;
        end else if (w_grant) begin
            r_lastGnt <= w_pick;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and the grant/capture strobes.
    always_comb begin
        w_nextState = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    w_grant     = 1'b1;
                    w_nextState = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_nextState = S_ACK;
                end
            end
            S_ACK:   w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Latch the winning access, run the wait counter, capture read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_grantId <= 1'b0;
            r_m0Rdata <= '0;
            r_m1Rdata <= '0;
        end else begin
            if (w_grant) begin
                r_we      <= w_pick ? m1_we    : m0_we;
                r_addr    <= w_pick ? m1_addr  : m0_addr;
                r_wdata   <= w_pick ? m1_wdata : m0_wdata;
                r_grantId <= w_pick;
                r_cnt     <= C_WAIT_LOAD;
            end else if ((r_state == S_ACCESS) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture && !r_we) begin
                if (r_grantId) begin
                    r_m1Rdata <= mem_rdata;
                end else begin
                    r_m0Rdata <= mem_rdata;
                end
            end
        end
    end

    // Outputs decoded from state and latched registers only.
    always_comb begin
        mem_addr  = (r_state == S_ACCESS) ? r_addr  : '0;
        mem_wdata = (r_state == S_ACCESS) ? r_wdata : '0;
        mem_we    = w_capture & r_we;
        m0_ack    = (r_state == S_ACK) && !r_grantId;
        m1_ack    = (r_state == S_ACK) &&  r_grantId;
        m0_rdata  = r_m0Rdata;
        m1_rdata  = r_m1Rdata;
        busy      = (r_state != S_IDLE);
        grant_id  = r_grantId;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter for the single unified instruction/data memory port of the multicycle RISC-V core. It serialises accesses from requester 0 (core fetch/load/store path) and requester 1 (program loader/debug port). Each winning access is latched and driven onto the memory bus for a programmable number of wait states, then acknowledged with registered read data. Arbitration is round-robin by default.

## Interface
- DATA_WIDTH, 32, width of write/read data
- ADDR_WIDTH, 32, width of byte address
- WAIT_STATES, 1, extra memory cycles per access (legal 0..15)

- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- m0_req / m1_req  input  1  access request; held high until ack
- m0_we / m1_we  input  1  1 = write, 0 = read; stable while req high
- m0_addr / m1_addr  input  ADDR_WIDTH  byte address; stable while req high
- m0_wdata / m1_wdata  input  DATA_WIDTH  write data; stable while req high
- m0_ack / m1_ack  output  1  one-cycle completion pulse
- m0_rdata / m1_rdata  output  DATA_WIDTH  registered read data, valid when ack high, held afterwards
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_we  output  1  memory write enable (memory writes on clock edge)
- mem_rdata  input  DATA_WIDTH  memory read data, combinational from mem_addr
- busy  output  1  high in ACCESS and ACK states
- grant_id  output  1  index of current/last granted requester

## Operation
- States: IDLE, ACCESS, ACK. Reset state IDLE.
- IDLE: req lines sampled each cycle. None high -> stay. One high -> grant it. Both high -> grant requester not in last_gnt. On grant: latch we/addr/wdata, set grant_id and last_gnt, load wait counter with WAIT_STATES, go ACCESS.
- ACCESS: mem_addr/mem_wdata driven from latched values. Counter decrements each cycle; when counter = 0: mem_we = latched we for exactly that cycle, mem_rdata captured into granted port's rdata register (reads only; on writes rdata holds), go ACK.
- ACK: ack of granted port = 1 for one cycle; go IDLE unconditionally.
- Outside ACCESS: mem_addr = 0, mem_wdata = 0, mem_we = 0.
- Non-granted port: ack stays 0, rdata unchanged.
- Requester deasserts req in the cycle after seeing ack; req still high in IDLE is a new access (back-to-back allowed).
- Requests arriving during ACCESS/ACK wait; never dropped while held.
- Reset values: state IDLE, all acks 0, both rdata 0, mem_* 0, busy 0, grant_id 0, last_gnt 1 (first tie goes to requester 0).
- Reset asserted mid-access: immediate return to IDLE, mem_we forced 0 asynchronously, no ack issued; requester must reissue.
- Counter width 4 bits; WAIT_STATES outside 0..15 is illegal.

## Timing
- req high in cycle T (state IDLE) -> ACCESS from T+1 through T+1+WAIT_STATES -> ack in cycle T+2+WAIT_STATES.
- Latency req->ack = WAIT_STATES+2 cycles; throughput one access per WAIT_STATES+3 cycles with continuous req.
- mem_we high exactly one cycle per write, in the final ACCESS cycle.
- All outputs registered or decoded from state/latched registers only; no combinational path from m*_req/addr to mem_* outputs.

## Configuration
- MEM_ARB_FIXED_PRIO_EN defined: ties resolved with fixed priority, requester 0 always wins; last_gnt unused for decisions (grant_id still updated).
- Undefined: round-robin as described in Operation.

## Test plan
- Single read, WAIT_STATES=1: m0 reads addr 0x10 (mem holds 0xDEADBEEF) -> m0_ack at req+3, m0_rdata=0xDEADBEEF, m1_ack stays 0.
- Single write: m1 writes 0x12345678 to 0x20 -> mem_we high exactly one cycle with mem_addr=0x20, m1_ack at req+3; later m0 read of 0x20 returns 0x12345678.
- Contention, round-robin: both req held continuously from reset -> grants alternate 0,1,0,1 (grant_id), acks every 4 cycles; with MEM_ARB_FIXED_PRIO_EN, grants 0,0,0,... and m1 starves.
- WAIT_STATES=0 and 15: m0 read -> ack at req+2 and req+17 respectively; mem_addr stable for 1 and 16 cycles.
- Reset mid-access: assert reset low during ACCESS of a write -> mem_we 0 immediately, no ack, state IDLE, outputs at reset values; reissued write completes normally.
- Late arrival: m1_req rises while m0 in ACCESS -> m1 granted in cycle after m0's ack cycle, m0 data unaffected.
